// File: rtl/axis_wrr_sched_4.sv
// Weighted round-robin packet scheduler for a 4-input AXI-Stream mux; grants whole packets.
// Optional watchdog guarded by AXIS_WRR_WATCHDOG_EN (undefined: o_timeout tied low).
module axis_wrr_sched_4 #(
  parameter int WEIGHT_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int RESET_PTR      = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3:0]                i_req,
  input  logic [4*WEIGHT_WIDTH-1:0] i_weight,
  input  logic                      i_beat_xfer,
  input  logic                      i_beat_last,
  output logic [3:0]                o_grant,
  output logic                      o_grant_valid,
  output logic [1:0]                o_grant_index,
  output logic                      o_pkt_done,
  output logic                      o_timeout
);
  localparam int WW = WEIGHT_WIDTH;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_ptr, w_ptr_nxt;
  logic [1:0]      r_idx, w_idx_nxt;
  logic [3:0]      r_grant, w_grant_nxt;
  logic [WW-1:0]   r_credit, w_credit_nxt;
  logic            r_pkt_done, w_pkt_done_nxt;
  logic            r_timeout, w_timeout_nxt;
  logic [1:0]      w_pick;
  logic            w_found;
  logic [WW-1:0]   w_wsel;
  logic            w_last;

`ifdef AXIS_WRR_WATCHDOG_EN
  localparam int WDW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WDW-1:0]  r_wd_cnt, w_wd_nxt;
  logic            w_wd_expire;
  assign w_wd_expire = (r_wd_cnt == WDW'(TIMEOUT_CYCLES - 1));
`endif

  assign w_last = i_beat_xfer & i_beat_last;

  // Descending scan so the lowest offset from r_ptr is the one that sticks.
  always_comb begin
    w_pick  = r_ptr;
    w_found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (i_req[r_ptr + 2'(i)]) begin
        w_pick  = r_ptr + 2'(i);
        w_found = 1'b1;
      end
    end
  end

  assign w_wsel = i_weight[int'(w_pick)*WW +: WW];

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_idx_nxt      = r_idx;
    w_grant_nxt    = r_grant;
    w_credit_nxt   = r_credit;
    w_pkt_done_nxt = 1'b0;
    w_timeout_nxt  = 1'b0;
`ifdef AXIS_WRR_WATCHDOG_EN
    w_wd_nxt       = r_wd_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt  = ST_BUSY;
          w_idx_nxt    = w_pick;
          w_grant_nxt  = 4'b0001 << w_pick;
          w_credit_nxt = (w_wsel == '0) ? WW'(1) : w_wsel;
`ifdef AXIS_WRR_WATCHDOG_EN
          w_wd_nxt     = '0;
`endif
        end
      end
      ST_BUSY: begin
        if (w_last) begin
          w_pkt_done_nxt = 1'b1;
          w_credit_nxt   = r_credit - WW'(1);
          if (!(r_credit > WW'(1) && i_req[r_idx])) begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = 4'b0000;
            w_ptr_nxt   = r_idx + 2'd1;
          end
        end
`ifdef AXIS_WRR_WATCHDOG_EN
        if (i_beat_xfer) begin
          w_wd_nxt = '0;
        end else if (w_wd_expire) begin
          w_wd_nxt      = '0;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
          w_grant_nxt   = 4'b0000;
          w_ptr_nxt     = r_idx + 2'd1;
        end else begin
          w_wd_nxt = r_wd_cnt + WDW'(1);
        end
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 2'(RESET_PTR);
      r_idx      <= 2'd0;
      r_grant    <= 4'b0000;
      r_credit   <= '0;
      r_pkt_done <= 1'b0;
      r_timeout  <= 1'b0;
`ifdef AXIS_WRR_WATCHDOG_EN
      r_wd_cnt   <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_idx      <= w_idx_nxt;
      r_grant    <= w_grant_nxt;
      r_credit   <= w_credit_nxt;
      r_pkt_done <= w_pkt_done_nxt;
      r_timeout  <= w_timeout_nxt;
`ifdef AXIS_WRR_WATCHDOG_EN
      r_wd_cnt   <= w_wd_nxt;
`endif
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_valid = |r_grant;
  assign o_grant_index = r_idx;
  assign o_pkt_done    = r_pkt_done;
`ifdef AXIS_WRR_WATCHDOG_EN
  assign o_timeout     = r_timeout;
`else
  assign o_timeout     = 1'b0;
`endif

endmodule
